// File: rtl/il_block_arbiter.sv
// il_block_arbiter: shares one pre-interleaver input among NUM_SRC AXI-Stream
// sources. Grants last for one whole interleaver block of BLOCK_SIZE words.
// Arbitration between blocks is round-robin. A block that its source ends
// early with tlast is padded with PAD_WORD up to BLOCK_SIZE words.
module il_block_arbiter #(
  parameter int unsigned NUM_SRC             = 2,
  parameter int unsigned CODEWORD_SIZE_IN_32 = 65,
  parameter int unsigned NUM_CODEWORDS       = 4,
  parameter logic [31:0] PAD_WORD            = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [32*NUM_SRC-1:0]      s_axis_tdata,
  input  logic [NUM_SRC-1:0]         s_axis_tvalid,
  input  logic [NUM_SRC-1:0]         s_axis_tlast,
  output logic [NUM_SRC-1:0]         s_axis_tready,
  output logic [31:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(NUM_SRC)-1:0] m_axis_tuser,
  output logic                       blk_done
);

  localparam int unsigned BLOCK_SIZE = CODEWORD_SIZE_IN_32 * NUM_CODEWORDS;
  localparam int unsigned CNT_W      = $clog2(BLOCK_SIZE);
  localparam int unsigned SRC_W      = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);
  localparam logic [SRC_W:0]   NSRC_EXT = (SRC_W+1)'(NUM_SRC);

  typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [SRC_W-1:0] grant, grant_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
  logic             blk_done_nxt;
  logic             hs;
  logic             at_last;
  logic [SRC_W:0]   cand;
  logic             srch_found;
  logic [SRC_W-1:0] srch_pick;

  assign hs      = m_axis_tvalid & m_axis_tready;
  assign at_last = (word_cnt == LAST_IDX);

  // State register plus block counter, grant, round-robin pointer and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      grant    <= '0;
      rr_ptr   <= '0;
      blk_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      blk_done <= blk_done_nxt;
    end
  end

  // Circular search from rr_ptr for the first requester
  always_comb begin
    srch_found = 1'b0;
    srch_pick  = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      // rr_ptr + i folded back into 0..NUM_SRC-1 without a modulo operator
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (cand >= NSRC_EXT) cand = cand - NSRC_EXT;
      if (!srch_found && s_axis_tvalid[cand[SRC_W-1:0]]) begin
        srch_found = 1'b1;
        srch_pick  = cand[SRC_W-1:0];
      end
    end
  end

  // Next-state logic: grant in IDLE, count words through PASS/PAD, close the block
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    blk_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (srch_found) begin
          grant_nxt    = srch_pick;
          rr_ptr_nxt   = (srch_pick == LAST_SRC) ? '0 : srch_pick + 1'b1;
          word_cnt_nxt = '0;
          state_nxt    = PASS;
        end
      end
      PASS: begin
        if (hs) begin
          if (at_last) begin
            // source tlast is ignored on the block-final word
            state_nxt    = IDLE;
            word_cnt_nxt = '0;
            blk_done_nxt = 1'b1;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
            if (s_axis_tlast[grant]) state_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (hs) begin
          if (at_last) begin
            state_nxt    = IDLE;
            word_cnt_nxt = '0;
            blk_done_nxt = 1'b1;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: pass-through of the granted source, pad words, or silence
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    case (state)
      PASS: begin
        m_axis_tvalid        = s_axis_tvalid[grant];
        m_axis_tdata         = s_axis_tdata[32*grant +: 32];
        s_axis_tready[grant] = m_axis_tready;
        m_axis_tlast         = at_last;
        m_axis_tuser         = grant;
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PAD_WORD;
        m_axis_tlast  = at_last;
        m_axis_tuser  = grant;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_il_block_arbiter.sv
// Bench for il_block_arbiter with BLOCK_SIZE=6 and two sources. Source queues
// drive the slave ports; expected output words go into a scoreboard queue that a
// separate monitor pops on each output handshake.
module tb_il_block_arbiter;

  localparam int          BS   = 6;
  localparam logic [31:0] PADW = 32'hFADE_0000;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tlast;
  logic [1:0]  s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic        blk_done;

  il_block_arbiter #(
    .NUM_SRC(2),
    .CODEWORD_SIZE_IN_32(3),
    .NUM_CODEWORDS(2),
    .PAD_WORD(PADW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser),
    .blk_done(blk_done)
  );

  typedef struct packed {
    logic        pad;
    logic        user;
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  int          checks;
  int          errors;
  int          exp_pos;
  int          done_cnt;
  bit          rand_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_src(input int s, input int n, input logic [31:0] base, input bit tl);
    logic [32:0] w;
    for (int i = 0; i < n; i++) begin
      w = {(tl && i == n - 1), base + 32'(i)};
      if (s == 0) q0.push_back(w);
      else q1.push_back(w);
    end
  endtask

  task automatic exp_data(input logic user, input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pad  = 1'b0;
      e.user = user;
      e.last = (exp_pos == BS - 1);
      e.data = base + 32'(i);
      exp_q.push_back(e);
      exp_pos = (exp_pos + 1) % BS;
    end
  endtask

  task automatic exp_pads(input logic user, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pad  = 1'b1;
      e.user = user;
      e.last = (exp_pos == BS - 1);
      e.data = PADW;
      exp_q.push_back(e);
      exp_pos = (exp_pos + 1) % BS;
    end
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), cyc);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Source models: present queue heads, retire a word after its handshake
  initial begin : pump
    bit f0, f1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      f0 = s_tvalid[0] & s_tready[0];
      f1 = s_tvalid[1] & s_tready[1];
      @(posedge clk);
      #1;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (f1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        s_tvalid[0] = 1'b1; s_tdata[31:0] = q0[0][31:0]; s_tlast[0] = q0[0][32];
      end else begin
        s_tvalid[0] = 1'b0; s_tdata[31:0] = '0; s_tlast[0] = 1'b0;
      end
      if (q1.size() > 0) begin
        s_tvalid[1] = 1'b1; s_tdata[63:32] = q1[0][31:0]; s_tlast[1] = q1[0][32];
      end else begin
        s_tvalid[1] = 1'b0; s_tdata[63:32] = '0; s_tlast[1] = 1'b0;
      end
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  exp_t        mon_e;
  logic        pending_done;
  logic        prev_stall;
  logic [31:0] prev_data;

  // Monitor: score every output handshake, tready exclusivity, stall stability, done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      pending_done = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (blk_done) done_cnt++;
      if (pending_done || blk_done) chk("blk_done", blk_done, pending_done);
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1'b1);
        chk("stall_data", m_tdata, prev_data);
      end
      if (m_tvalid) chk("other_tready", s_tready[~m_tuser], 1'b0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", m_tdata, mon_e.data);
          chk("last", m_tlast, mon_e.last);
          chk("user", m_tuser, mon_e.user);
          if (mon_e.pad) chk("pad_tready", s_tready, 2'b00);
        end
      end
      pending_done = m_tvalid & m_tready & m_tlast;
      prev_stall   = m_tvalid & ~m_tready;
      prev_data    = m_tdata;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    checks = 0; errors = 0; exp_pos = 0; done_cnt = 0; rand_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_s_tready", s_tready, 2'b00);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tuser", m_tuser, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_blk_done", blk_done, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    settle(2);
    chk("idle_m_tvalid", m_tvalid, 1'b0);
    chk("idle_s_tready", s_tready, 2'b00);

    // full 6-word block from src0: one bubble cycle then six words
    push_src(0, 6, 32'h1000_0000, 1'b0);
    exp_data(1'b0, 32'h1000_0000, 6);
    wait_drain(cyc);
    chk("t1_latency", 32'(cyc), 32'd7);
    settle(3);

    // short frame from src0 padded to the block size
    push_src(0, 2, 32'h2000_0000, 1'b1);
    exp_data(1'b0, 32'h2000_0000, 2);
    exp_pads(1'b0, 4);
    wait_drain(cyc);
    settle(3);

    // 9-word frame from src1 spans a full block plus a padded one
    push_src(1, 9, 32'h5000_0000, 1'b1);
    exp_data(1'b1, 32'h5000_0000, 6);
    exp_data(1'b1, 32'h5000_0006, 3);
    exp_pads(1'b1, 3);
    wait_drain(cyc);
    settle(3);

    // both sources requesting continuously: blocks alternate 0,1,0,1
    push_src(0, 12, 32'h3000_0000, 1'b0);
    push_src(1, 12, 32'h3100_0000, 1'b0);
    exp_data(1'b0, 32'h3000_0000, 6);
    exp_data(1'b1, 32'h3100_0000, 6);
    exp_data(1'b0, 32'h3000_0006, 6);
    exp_data(1'b1, 32'h3100_0006, 6);
    wait_drain(cyc);
    settle(3);

    // random downstream backpressure through PASS and PAD
    rand_ready = 1;
    push_src(0, 3, 32'h4000_0000, 1'b1);
    push_src(1, 6, 32'h4100_0000, 1'b0);
    exp_data(1'b0, 32'h4000_0000, 3);
    exp_pads(1'b0, 3);
    exp_data(1'b1, 32'h4100_0000, 6);
    wait_drain(cyc);
    rand_ready = 0;
    settle(3);

    // reset after three words of a block; afterwards src0 wins again
    push_src(0, 6, 32'h6000_0000, 1'b0);
    exp_data(1'b0, 32'h6000_0000, 3);
    wait_drain(cyc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 1'b0);
    chk("mid_rst_s_tready", s_tready, 2'b00);
    chk("mid_rst_m_tlast", m_tlast, 1'b0);
    chk("mid_rst_m_tuser", m_tuser, 1'b0);
    chk("mid_rst_m_tdata", m_tdata, 32'h0);
    chk("mid_rst_blk_done", blk_done, 1'b0);
    q0.delete();
    exp_pos = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    settle(1);
    push_src(0, 6, 32'h6100_0000, 1'b0);
    push_src(1, 6, 32'h6200_0000, 1'b0);
    exp_data(1'b0, 32'h6100_0000, 6);
    exp_data(1'b1, 32'h6200_0000, 6);
    wait_drain(cyc);
    settle(4);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("blk_done_count", 32'(done_cnt), 32'd12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
